// File: rtl/step_clk_gen_if.sv
// Switch inputs and conditioned CPU clock/reset outputs of step_clk_gen.
// sw_run exists only when STEP_AUTORUN_EN is defined.
interface step_clk_gen_if;
    // No valid/ready handshake here: switches are raw asynchronous levels, and the
    // outputs are registered levels that are valid on every clk cycle after reset.
    logic        sw_step;
    logic        sw_reset;
`ifdef STEP_AUTORUN_EN
    logic        sw_run;
`endif
    logic        step_clk;
    logic        cpu_reset;
    logic [15:0] step_count;

`ifdef STEP_AUTORUN_EN
    modport master (output sw_step, sw_reset, sw_run, input step_clk, cpu_reset, step_count);
    modport slave  (input sw_step, sw_reset, sw_run, output step_clk, cpu_reset, step_count);
`else
    modport master (output sw_step, sw_reset, input step_clk, cpu_reset, step_count);
    modport slave  (input sw_step, sw_reset, output step_clk, cpu_reset, step_count);
`endif
endinterface

// File: rtl/step_clk_gen.sv
// Debounced single-step clock and reset generator for the single-cycle CPU.
// Optional auto-run stepping is built when STEP_AUTORUN_EN is defined.
module step_clk_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20,
`ifdef STEP_AUTORUN_EN
    parameter int AUTO_PERIOD     = 50_000_000,
`endif
    parameter int PULSE_CYCLES    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    step_clk_gen_if.slave    sif,
    output logic [1:0]       dbg_state
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

`ifdef STEP_AUTORUN_EN
    localparam int N_SW = 3;
    localparam int AW   = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
`else
    localparam int N_SW = 2;
`endif

    // Bit 0 = step, bit 1 = reset, bit 2 = run (auto-run builds only).
    logic [N_SW-1:0] raw, sync1, sync2, stable, stable_nxt;
    logic [CNT_W-1:0] cnt [N_SW];
    logic [CNT_W-1:0] cnt_nxt [N_SW];

`ifdef STEP_AUTORUN_EN
    assign raw = {sif.sw_run, sif.sw_reset, sif.sw_step};
`else
    assign raw = {sif.sw_reset, sif.sw_step};
`endif

    // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < N_SW; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            stable <= stable_nxt;
            for (int i = 0; i < N_SW; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    logic [1:0]    state, state_nxt;
    logic [PW-1:0] pcnt, pcnt_nxt;
    logic          step_d;
    logic          start;
    logic          run_lvl;

`ifdef STEP_AUTORUN_EN
    logic [AW-1:0] per_cnt;
    assign run_lvl = stable[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt <= '0;
        end else if (!run_lvl || per_cnt == AW'(AUTO_PERIOD - 1)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // In auto-run the period counter owns stepping and manual presses are ignored.
    always_comb begin
        start = 1'b0;
        if (state == IDLE) begin
            if (run_lvl) start = (per_cnt == AW'(AUTO_PERIOD - 1));
            else         start = stable[0] & ~step_d;
        end
    end
`else
    assign run_lvl = 1'b0;
    assign start   = (state == IDLE) & stable[0] & ~step_d;
`endif

    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        case (state)
            IDLE: if (start) begin
                state_nxt = HIGH;
                pcnt_nxt  = '0;
            end
            HIGH: if (pcnt == PW'(PULSE_CYCLES - 1)) begin
                state_nxt = run_lvl ? IDLE : WAIT;
                pcnt_nxt  = '0;
            end else begin
                pcnt_nxt = pcnt + 1'b1;
            end
            WAIT: if (!stable[0]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset clear uses the next stable level so a coincident reset rise beats a step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pcnt           <= '0;
            step_d         <= 1'b0;
            sif.step_clk   <= 1'b0;
            sif.step_count <= '0;
        end else begin
            state        <= state_nxt;
            pcnt         <= pcnt_nxt;
            step_d       <= stable[0];
            sif.step_clk <= (state_nxt == HIGH);
            if (stable_nxt[1]) begin
                sif.step_count <= '0;
            end else if (start) begin
                sif.step_count <= sif.step_count + 16'd1;
            end
        end
    end

    assign sif.cpu_reset = stable[1];
    assign dbg_state     = state;
endmodule

// File: tb/tb_step_clk_gen.sv
// Bench for step_clk_gen: per-cycle model comparison plus directed literal checks.
module tb_step_clk_gen;
  localparam int DEB = 4;
  localparam int PUL = 3;
  localparam int AP  = 10;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbg_state;
  logic       load_ffff;
  int         n_cmp;
  int         n_bad;
  int         pulse_cnt;

  step_clk_gen_if sc_if ();

  step_clk_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
`ifdef STEP_AUTORUN_EN
    .AUTO_PERIOD(AP),
`endif
    .PULSE_CYCLES(PUL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sif(sc_if.slave),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  bit [2:0]    m_sync1, m_sync2, m_stab, m_old, raw;
  int          m_run [3];
  int          m_phase;   // 0 idle, 1 high, 2 wait
  int          m_left;
  int          m_per;
  bit          m_prev_step;
  bit          m_started;
  logic [15:0] m_count;
  bit          run_in;

`ifdef STEP_AUTORUN_EN
  assign run_in = sc_if.sw_run;
`else
  assign run_in = 1'b0;
`endif

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_sync1 = '0; m_sync2 = '0; m_stab = '0;
      for (int k = 0; k < 3; k++) m_run[k] = 0;
      m_phase = 0; m_left = 0; m_per = 0; m_prev_step = 0; m_count = '0;
    end else begin
      raw = {run_in, sc_if.sw_reset, sc_if.sw_step};
      m_old = m_stab;
      if (load_ffff) m_count = 16'hFFFF;
      m_started = 0;
      // pulse engine reacts to the levels as they stood before this edge
      if (m_phase == 0) begin
        if (m_old[2] ? (m_per == AP - 1) : (m_old[0] && !m_prev_step)) begin
          m_phase = 1; m_left = PUL; m_started = 1;
        end
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = m_old[2] ? 0 : 2;
      end else if (!m_old[0]) begin
        m_phase = 0;
      end
      m_per = (m_old[2] && m_per != AP - 1) ? m_per + 1 : 0;
      m_prev_step = m_old[0];
      for (int k = 0; k < 3; k++) begin
        if (m_sync2[k] != m_stab[k]) begin
          if (m_run[k] == DEB - 1) begin
            m_stab[k] = m_sync2[k];
            m_run[k] = 0;
          end else begin
            m_run[k]++;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = raw;
      if (m_stab[1]) m_count = '0;
      else if (m_started) m_count = m_count + 16'd1;
    end
  end

  // scoreboard compare on every falling edge
  initial forever begin
    @(negedge clk);
    chk("step_clk_model", {31'd0, sc_if.step_clk}, {31'd0, m_phase == 1});
    chk("cpu_reset_model", {31'd0, sc_if.cpu_reset}, {31'd0, m_stab[1]});
    chk("step_count_model", {16'd0, sc_if.step_count}, {16'd0, m_count});
  end

  initial begin
    pulse_cnt = 0;
    forever begin
      @(posedge sc_if.step_clk);
      pulse_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input int hold);
    sc_if.sw_step = 1'b1;
    wait_n(hold);
    sc_if.sw_step = 1'b0;
    wait_n(12);
  endtask

  int p0, p1;

  initial begin
    n_cmp = 0; n_bad = 0; load_ffff = 1'b0;
    reset_n = 1'b0;
    sc_if.sw_step = 1'b0;
    sc_if.sw_reset = 1'b0;
`ifdef STEP_AUTORUN_EN
    sc_if.sw_run = 1'b0;
`endif
    wait_n(3);
    chk("rst_step_clk", {31'd0, sc_if.step_clk}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    reset_n = 1'b1;
    wait_n(3);
    chk("rel_cpu_reset", {31'd0, sc_if.cpu_reset}, 32'd0);
    chk("rel_step_count", {16'd0, sc_if.step_count}, 32'd0);

    // clean press held 20 cycles
    p0 = pulse_cnt;
    sc_if.sw_step = 1'b1;
    wait_n(6);  chk("t2_low_edge6", {31'd0, sc_if.step_clk}, 32'd0);
    wait_n(1);  chk("t2_high_edge7", {31'd0, sc_if.step_clk}, 32'd1);
    wait_n(2);  chk("t2_high_edge9", {31'd0, sc_if.step_clk}, 32'd1);
    wait_n(1);  chk("t2_low_edge10", {31'd0, sc_if.step_clk}, 32'd0);
    chk("t2_count", {16'd0, sc_if.step_count}, 32'd1);
    wait_n(10);
    sc_if.sw_step = 1'b0;
    wait_n(12);
    chk("t2_one_pulse", pulse_cnt - p0, 32'd1);

    // bouncing press 1,0,1,0 then hold 1
    p0 = pulse_cnt;
    sc_if.sw_step = 1'b1; wait_n(2);
    sc_if.sw_step = 1'b0; wait_n(2);
    sc_if.sw_step = 1'b1; wait_n(2);
    sc_if.sw_step = 1'b0; wait_n(2);
    sc_if.sw_step = 1'b1;
    wait_n(6);  chk("t3_low_edge6", {31'd0, sc_if.step_clk}, 32'd0);
    wait_n(1);  chk("t3_high_edge7", {31'd0, sc_if.step_clk}, 32'd1);
    wait_n(10);
    sc_if.sw_step = 1'b0;
    wait_n(12);
    chk("t3_one_pulse", pulse_cnt - p0, 32'd1);
    chk("t3_count", {16'd0, sc_if.step_count}, 32'd2);

    // third step, then CPU reset
    press(15);
    chk("t4_count3", {16'd0, sc_if.step_count}, 32'd3);
    sc_if.sw_reset = 1'b1;
    wait_n(5);  chk("t4_rst_edge5", {31'd0, sc_if.cpu_reset}, 32'd0);
    wait_n(1);  chk("t4_rst_edge6", {31'd0, sc_if.cpu_reset}, 32'd1);
    chk("t4_count_clr", {16'd0, sc_if.step_count}, 32'd0);
    p0 = pulse_cnt;
    press(15);
    chk("t4_pulse_in_rst", pulse_cnt - p0, 32'd1);
    chk("t4_count_held", {16'd0, sc_if.step_count}, 32'd0);
    sc_if.sw_reset = 1'b0;
    wait_n(10);
    chk("t4_rst_released", {31'd0, sc_if.cpu_reset}, 32'd0);

    // wrap from 0xFFFF
    @(negedge clk);
    #2;
    load_ffff = 1'b1;
    force sc_if.step_count = 16'hFFFF;
    #1;
    release sc_if.step_count;
    @(negedge clk);
    load_ffff = 1'b0;
    chk("t5_preload", {16'd0, sc_if.step_count}, 32'h0000FFFF);
    sc_if.sw_step = 1'b1;
    wait_n(7);
    chk("t5_wrap_high", {31'd0, sc_if.step_clk}, 32'd1);
    chk("t5_wrap_count", {16'd0, sc_if.step_count}, 32'd0);
    wait_n(8);
    sc_if.sw_step = 1'b0;
    wait_n(12);

    // async reset during HIGH
    sc_if.sw_step = 1'b1;
    wait_n(8);
    chk("t5_mid_high", {31'd0, sc_if.step_clk}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_drop", {31'd0, sc_if.step_clk}, 32'd0);
    sc_if.sw_step = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    p0 = pulse_cnt;
    wait_n(20);
    chk("t5_no_resume", pulse_cnt - p0, 32'd0);
    chk("t5_count_rst", {16'd0, sc_if.step_count}, 32'd0);

`ifdef STEP_AUTORUN_EN
    // auto-run for 45 cycles
    p0 = pulse_cnt;
    sc_if.sw_run = 1'b1;
    wait_n(45);
    sc_if.sw_run = 1'b0;
    wait_n(10);
    p1 = pulse_cnt;
    chk("t6_auto_pulses", p1 - p0, 32'd4);
    wait_n(30);
    chk("t6_stopped", pulse_cnt - p1, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
